mux_2x1_4b: RTL and testbench

- 4-bit, two-input word multiplexer for the datapath component library.
- Primary output `out` is purely combinational: `num1` when `s`=1, else `num0`.
- A registered copy of the selected word is also provided for pipelined consumers. It runs on the single block clock with asynchronous active-high reset.
- Instantiated wherever a datapath stage chooses between two 4-bit operands (register-file write data, ALU operand select).

---
 rtl/mux_2x1_4b_pkg.sv | 4 +
 rtl/mux_2x1_4b_bit.sv | 9 +
 rtl/mux_2x1_4b.sv | 37 +++
 tb/tb_mux_2x1_4b.sv | 108 ++++++++++
 4 files changed

// File: rtl/mux_2x1_4b_pkg.sv
// mux_2x1_4b_pkg: shared defaults for the word multiplexer library
package mux_2x1_4b_pkg;
   localparam int WIDTH_DEFAULT = 4;
endpackage

// File: rtl/mux_2x1_4b_bit.sv
// mux_2x1_1b: single-bit 2:1 select, differing inputs merge to X on unknown select
module mux_2x1_1b (
   output logic out,
   input  logic num0,
   input  logic num1,
   input  logic s
);
   assign out = s ? num1 : num0;
endmodule

// File: rtl/mux_2x1_4b.sv
// mux_2x1_4b: WIDTH-bit 2:1 word mux with a registered copy of the selected word
module mux_2x1_4b
   import mux_2x1_4b_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   output logic [WIDTH-1:0] out,
   input  logic [WIDTH-1:0] num0,
   input  logic [WIDTH-1:0] num1,
   input  logic             s,
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] out_q,
   output logic             s_q
);
   genvar i;
   generate
      for (i = 0; i < WIDTH; i++) begin : g_bit
         mux_2x1_1b u_bit (
            .out  (out[i]),
            .num0 (num0[i]),
            .num1 (num1[i]),
            .s    (s)
         );
      end
   endgenerate
   // capture the selected word and its select one cycle later, cleared at once by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         s_q   <= 1'b0;
      end else begin
         out_q <= out;
         s_q   <= s;
      end
   end
endmodule

// File: tb/tb_mux_2x1_4b.sv
// tb_mux_2x1_4b: table-driven and sequence checks of the combinational and registered paths
module tb_mux_2x1_4b;
   logic [3:0] out, num0, num1, out_q;
   logic       s, clk, rst, s_q, clk_en;
   int         errs = 0;
   int         checks = 0;

   typedef struct {
      logic [3:0] n0;
      logic [3:0] n1;
      logic       sel;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs [8];

   mux_2x1_4b #(.WIDTH(4)) dut (
      .out   (out),
      .num0  (num0),
      .num1  (num1),
      .s     (s),
      .clk   (clk),
      .rst   (rst),
      .out_q (out_q),
      .s_q   (s_q)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = clk_en ? ~clk : 1'b0;
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   initial begin
      vecs[0] = '{4'b1100, 4'b0011, 1'b0, 4'b1100};
      vecs[1] = '{4'b1100, 4'b0011, 1'b1, 4'b0011};
      vecs[2] = '{4'b1001, 4'b0110, 1'b0, 4'b1001};
      vecs[3] = '{4'b1001, 4'b0110, 1'b1, 4'b0110};
      vecs[4] = '{4'b1101, 4'b1011, 1'b0, 4'b1101};
      vecs[5] = '{4'b1101, 4'b1011, 1'b1, 4'b1011};
      vecs[6] = '{4'b1111, 4'b0000, 1'b0, 4'b1111};
      vecs[7] = '{4'b1111, 4'b0000, 1'b1, 4'b0000};
      clk_en = 1'b0;
      rst = 1'b0;
      num0 = 4'b0000;
      num1 = 4'b0000;
      s = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_out_q", out_q, 4'b0000);
      check("rst_s_q", {3'b000, s_q}, 4'b0000);
      #2 rst = 1'b0;
      num1 = 4'b0110;
      s = 1'b1;
      #1;
      check("comb_before_edge", out, 4'b0110);
      check("out_q_before_edge", out_q, 4'b0000);
      clk_en = 1'b1;
      @(posedge clk);
      #1;
      check("first_edge_out_q", out_q, 4'b0110);
      check("first_edge_s_q", {3'b000, s_q}, 4'b0001);
      for (int i = 0; i < 8; i++) begin
         num0 = vecs[i].n0;
         num1 = vecs[i].n1;
         s = vecs[i].sel;
         #1;
         check($sformatf("vec%0d_out", i), out, vecs[i].exp);
         check($sformatf("vec%0d_hold", i), out_q, i == 0 ? 4'b0110 : vecs[i-1].exp);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_out_q", i), out_q, vecs[i].exp);
         check($sformatf("vec%0d_s_q", i), {3'b000, s_q}, {3'b000, vecs[i].sel});
      end
      num0 = 4'b1111;
      s = 1'b0;
      @(posedge clk);
      #1;
      check("pre_rst_out_q", out_q, 4'b1111);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out_q", out_q, 4'b0000);
      check("mid_rst_s_q", {3'b000, s_q}, 4'b0000);
      check("mid_rst_out", out, 4'b1111);
      num0 = 4'b1010;
      #1;
      check("rst_out_follows", out, 4'b1010);
      @(posedge clk);
      #1;
      check("rst_hold_out_q", out_q, 4'b0000);
      rst = 1'b0;
      s = 1'b1;
      num1 = 4'b0101;
      @(posedge clk);
      #1;
      check("release_out_q", out_q, 4'b0101);
      check("release_s_q", {3'b000, s_q}, 4'b0001);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
